// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: block-average raw ADC words, strip DC bias with a
// first-order IIR offset tracker, and deliver signed 16-bit samples over valid/ack.
module adc_sample_conditioner #(
  parameter int ADC_WIDTH  = 12,
  parameter int DECIM_LOG2 = 2,
  parameter int DC_SHIFT   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  output logic [15:0]          sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ack,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int ACC_W = ADC_WIDTH + DECIM_LOG2;
  localparam int OFS_W = ADC_WIDTH + DC_SHIFT;
  localparam int DIF_W = OFS_W + 2;
  localparam int CEN_W = ADC_WIDTH + 1;
  localparam int OUT_SH = 15 - ADC_WIDTH;
  localparam logic [OFS_W-1:0] OFS_MID = OFS_W'(1) << (ADC_WIDTH - 1 + DC_SHIFT);

  logic [ACC_W-1:0]      acc_q, acc_d, acc_sum;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [ADC_WIDTH-1:0]  avg_r_q, avg_r_d;
  logic [1:0]            vld_pipe_q, vld_pipe_d;
  logic [15:0]           res_q, res_d;
  logic [OFS_W-1:0]      offset_fp_q, offset_fp_d;
  logic [15:0]           sample_data_q, sample_data_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  overrun_q, overrun_d;

  logic [ADC_WIDTH-1:0]     offset;
  logic signed [CEN_W-1:0]  centered;
  logic signed [15:0]       cen_ext;
  logic signed [DIF_W-1:0]  ofs_diff, ofs_step, ofs_new;

  // Stage 1: block accumulator; the last word of a block produces avg_r.
  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    avg_r_d       = avg_r_q;
    vld_pipe_d[0] = 1'b0;
    acc_sum       = acc_q + ACC_W'(adc_data);
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (adc_valid) begin
      if (cnt_q == '1) begin
        avg_r_d       = acc_sum[ACC_W-1:DECIM_LOG2];
        vld_pipe_d[0] = 1'b1;
        acc_d         = '0;
        cnt_d         = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Stage 2: center against the pre-update offset, then nudge the tracker.
  always_comb begin
    offset        = offset_fp_q[OFS_W-1:DC_SHIFT];
    centered      = $signed({1'b0, avg_r_q}) - $signed({1'b0, offset});
    cen_ext       = {{(16-CEN_W){centered[CEN_W-1]}}, centered};
    ofs_diff      = $signed({2'b00, avg_r_q, {DC_SHIFT{1'b0}}}) - $signed({2'b00, offset_fp_q});
    ofs_step      = ofs_diff >>> DC_SHIFT;
    ofs_new       = $signed({2'b00, offset_fp_q}) + ofs_step;
    res_d         = res_q;
    offset_fp_d   = offset_fp_q;
    vld_pipe_d[1] = vld_pipe_q[0];
    if (vld_pipe_q[0]) begin
      res_d       = cen_ext <<< OUT_SH;
      offset_fp_d = ofs_new[OFS_W-1:0];
    end
  end

  // Output holding register; a new result always wins, flagging overrun if unconsumed.
  always_comb begin
    sample_data_d  = sample_data_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (vld_pipe_q[1]) begin
      sample_data_d  = res_q;
      sample_valid_d = 1'b1;
      if (sample_valid_q && !sample_ack) overrun_d = 1'b1;
    end else if (sample_valid_q && sample_ack) begin
      sample_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      cnt_q          <= '0;
      avg_r_q        <= '0;
      vld_pipe_q     <= '0;
      res_q          <= '0;
      offset_fp_q    <= OFS_MID;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      avg_r_q        <= avg_r_d;
      vld_pipe_q     <= vld_pipe_d;
      res_q          <= res_d;
      offset_fp_q    <= offset_fp_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed bench for adc_sample_conditioner: decimation, DC tracking,
// handshake/overrun behaviour and async reset, against hand-computed values.
module tb_adc_sample_conditioner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ack;
  logic        overrun;
  logic        overrun_clr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_sample_conditioner #(.ADC_WIDTH(12), .DECIM_LOG2(2), .DC_SHIFT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ack(sample_ack),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left on a falling edge.
  task automatic send_word(input int d);
    adc_data  = 12'(d);
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic send_block(input int d);
    for (int i = 0; i < 4; i++) send_word(d);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_ack();
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic int sd();
    return int'($signed(sample_data));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout obs=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst_n = 1'b0; enable = 1'b1; adc_data = '0; adc_valid = 1'b0;
    sample_ack = 1'b0; overrun_clr = 1'b0;
    wait_cyc(2);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: midscale block -> 0, two-edge latency
    send_block(2048);
    chk("t1_lat_n0", sample_valid, 0);
    @(negedge clk);
    chk("t1_lat_n1", sample_valid, 0);
    @(negedge clk);
    chk("t1_lat_n2", sample_valid, 1);
    chk("t1_data", sd(), 0);
    do_ack();

    // 2: words 0..3 -> avg 1 -> (1-2048)*8
    do_reset();
    for (int i = 0; i < 4; i++) send_word(i);
    wait_cyc(2);
    chk("t2_valid", sample_valid, 1);
    chk("t2_data", sd(), -16376);
    do_ack();

    // 4: overrun and handshake
    do_reset();
    send_block(2048);
    wait_cyc(2);
    chk("t4_first", sd(), 0);
    chk("t4_ovr0", overrun, 0);
    send_block(2560);
    wait_cyc(2);
    chk("t4_replace", sd(), 4096);
    chk("t4_valid", sample_valid, 1);
    chk("t4_ovr1", overrun, 1);
    do_ack();
    chk("t4_ack_valid", sample_valid, 0);
    chk("t4_ack_hold", sd(), 4096);
    chk("t4_ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("t4_ovr_clr", overrun, 0);
    send_block(2048);
    wait_cyc(2);
    chk("t4_third", sd(), -16);
    chk("t4_ovr_still0", overrun, 0);
    send_block(2048);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("t4_set_wins", overrun, 1);
    chk("t4_fourth", sd(), -8);
    do_ack();

    // 5: disable discards a partial block
    do_reset();
    send_word(100);
    send_word(100);
    enable = 1'b0;
    wait_cyc(3);
    enable = 1'b1;
    send_block(2048);
    wait_cyc(2);
    chk("t5_valid", sample_valid, 1);
    chk("t5_data", sd(), 0);
    do_ack();
    wait_cyc(8);
    chk("t5_one_only", sample_valid, 0);

    // 3: constant 3000 converges toward zero
    do_reset();
    for (int b = 0; b < 2000; b++) begin
      send_block(3000);
      wait_cyc(2);
      s = sd();
      if (b == 0) chk("t3_first", s, 7616);
      if (b == 1) chk("t3_second", s, 7592);
      do_ack();
    end
    chk("t3_conv", int'(s < 64 && s > -64), 1);

    // 6: async reset mid-block with a pending sample and overrun
    send_block(3000);
    wait_cyc(2);
    send_block(3000);
    wait_cyc(2);
    chk("t6_pre_valid", sample_valid, 1);
    chk("t6_pre_ovr", overrun, 1);
    for (int i = 0; i < 3; i++) send_word(3000);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", sample_valid, 0);
    chk("t6_rst_ovr", overrun, 0);
    chk("t6_rst_data", sample_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_block(2048);
    wait_cyc(2);
    chk("t6_post_valid", sample_valid, 1);
    chk("t6_post_data", sd(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
